// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared types and constants for the alu_exec execute unit.
//   alu_op_e   - 4-bit operation codes from the ALU controller
//   state_e    - top-level sequencing states (IDLE, SHIFT)
//   DATA_WIDTH_DEF - default operand/result width
//   is_shift_op - true for SLL/SRL/SRA
package alu_exec_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_SUB = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SLL = 4'b0011,
    OP_SRL = 4'b0100,
    OP_SRA = 4'b0101,
    OP_XOR = 4'b0110,
    OP_OR  = 4'b0111,
    OP_SLT = 4'b1000,
    OP_BEQ = 4'b1001
  } alu_op_e;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_shifter.sv
// alu_exec_shifter: iterative one-bit-per-cycle shifter.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   start             - load load_val/shamt and latch direction controls
//   left, arith       - shift left / arithmetic right (sign replicate)
//   load_val, shamt   - value to shift and number of steps
//   done              - high on the cycle whose edge performs the last step
//   shift_val         - working value after the current step
module alu_exec_shifter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  left,
  input  logic                  arith,
  input  logic [DATA_WIDTH-1:0] load_val,
  input  logic [SHAMT_W-1:0]    shamt,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] shift_val
);

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic [SHAMT_W-1:0]    cnt_q, cnt_d;
  logic                  left_q, left_d;
  logic                  arith_q, arith_d;

  always_comb begin
    if (left_q) begin
      shift_val = {work_q[DATA_WIDTH-2:0], 1'b0};
    end else begin
      shift_val = {arith_q & work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
    end
  end

  assign done = (cnt_q == CNT_ONE);

  always_comb begin
    work_d  = work_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    arith_d = arith_q;
    if (start) begin
      work_d  = load_val;
      cnt_d   = shamt;
      left_d  = left;
      arith_d = arith;
    end else if (cnt_q != '0) begin
      work_d = shift_val;
      cnt_d  = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work_q  <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      arith_q <= arith_d;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: multi-cycle integer execute unit with valid/ready on both sides.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   in_valid/in_ready       - input handshake (operation, src_a, src_b)
//   operation               - 4-bit op code (see alu_op_e)
//   src_a, src_b            - operands; src_b[SHAMT_W-1:0] is the shift amount
//   out_valid/out_ready     - output handshake
//   result, zero            - registered result and (result == 0)
//   busy                    - iterative shift in progress
// Build option: ALU_EXEC_BARREL_SHIFT_EN computes shifts combinationally in a
// single cycle; otherwise shifts iterate one bit per cycle in alu_exec_shifter.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            operation,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  busy
);

  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [SHAMT_W-1:0]    shamt;
  logic                  accept;

  assign shamt = src_b[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    case (operation)
      OP_AND: alu_res = src_a & src_b;
      OP_SUB: alu_res = src_a - src_b;
      OP_ADD: alu_res = src_a + src_b;
`ifdef ALU_EXEC_BARREL_SHIFT_EN
      OP_SLL: alu_res = src_a << shamt;
      OP_SRL: alu_res = src_a >> shamt;
      OP_SRA: alu_res = $unsigned($signed(src_a) >>> shamt);
`else
      // Only reaches the output register for a zero shift amount.
      OP_SLL, OP_SRL, OP_SRA: alu_res = src_a;
`endif
      OP_XOR: alu_res = src_a ^ src_b;
      OP_OR:  alu_res = src_a | src_b;
      OP_SLT: alu_res[0] = ($signed(src_a) < $signed(src_b));
      OP_BEQ: alu_res = src_a ^ src_b;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_EXEC_BARREL_SHIFT_EN

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign busy     = 1'b0;

  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      result_d    = alu_res;
      zero_d      = (alu_res == '0);
      out_valid_d = 1'b1;
    end
  end

`else

  state_e                state_q, state_d;
  logic                  shift_start;
  logic                  shift_done;
  logic [DATA_WIDTH-1:0] shift_val;

  assign in_ready    = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign shift_start = accept && is_shift_op(operation) && (shamt != '0);
  assign busy        = (state_q == SHIFT);

  alu_exec_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_W    (SHAMT_W)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .start     (shift_start),
    .left      (operation == OP_SLL),
    .arith     (operation == OP_SRA),
    .load_val  (src_a),
    .shamt     (shamt),
    .done      (shift_done),
    .shift_val (shift_val)
  );

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (shift_start) begin
          state_d = SHIFT;
        end else if (accept) begin
          result_d    = alu_res;
          zero_d      = (alu_res == '0);
          out_valid_d = 1'b1;
        end
      end
      SHIFT: begin
        if (shift_done) begin
          result_d    = shift_val;
          zero_d      = (shift_val == '0);
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int unsigned checks;
  int unsigned failures;

  alu_exec #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid  = 1'b1;
    operation = op;
    src_a     = a;
    src_b     = b;
  endtask

  // One-cycle op with out_ready high: accepted at the next edge, result visible after it.
  task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zero);
    issue(op, a, b);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_zero"}, 32'(zero), 32'(exp_zero));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    operation = 4'b0000;
    src_a     = '0;
    src_b     = '0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    single("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
    single("sub_eq", 4'b0001, 32'd5, 32'd5, 32'h0, 1'b1);
    single("sub_neg", 4'b0001, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0);
    single("slt_neg", 4'b1000, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0);
    single("slt_pos", 4'b1000, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1);
    single("beq_eq", 4'b1001, 32'h1234, 32'h1234, 32'h0, 1'b1);
    single("beq_ne", 4'b1001, 32'h1234, 32'h1235, 32'h1, 1'b0);
    single("undef", 4'b1011, 32'h5, 32'h3, 32'h0, 1'b1);
    single("and", 4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0);
    single("or", 4'b0111, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0);
    single("xor", 4'b0110, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0);
    single("sll0", 4'b0011, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b0);

`ifdef ALU_EXEC_BARREL_SHIFT_EN
    single("srl31", 4'b0100, 32'hF000_0000, 32'd31, 32'h1, 1'b0);
    check("srl31_busy", 32'(busy), 32'd0);
    single("sra4", 4'b0101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    check("sra4_busy", 32'(busy), 32'd0);
`else
    // SRA by 4: busy for 4 cycles, in_ready low, competing input ignored.
    issue(4'b0101, 32'h8000_0000, 32'd4);
    tick();
    issue(4'b0010, 32'h1, 32'h1);
    check("sra_busy_0", 32'(busy), 32'd1);
    check("sra_in_ready_0", 32'(in_ready), 32'd0);
    check("sra_out_valid_0", 32'(out_valid), 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("sra_busy_%0d", i), 32'(busy), 32'd1);
      check($sformatf("sra_in_ready_%0d", i), 32'(in_ready), 32'd0);
      check($sformatf("sra_out_valid_%0d", i), 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    tick();
    check("sra_done_busy", 32'(busy), 32'd0);
    check("sra_done_out_valid", 32'(out_valid), 32'd1);
    check("sra_done_result", result, 32'hF800_0000);
    check("sra_done_zero", 32'(zero), 32'd0);

    // SLL by 1 (minimum iterative latency), accepted while draining the SRA result.
    issue(4'b0011, 32'h8000_0001, 32'd1);
    tick();
    in_valid = 1'b0;
    check("sll1_busy", 32'(busy), 32'd1);
    check("sll1_out_valid_drop", 32'(out_valid), 32'd0);
    tick();
    check("sll1_out_valid", 32'(out_valid), 32'd1);
    check("sll1_result", result, 32'h0000_0002);
    check("sll1_busy_done", 32'(busy), 32'd0);

    // SRL shifting out to zero sets the zero flag.
    issue(4'b0100, 32'h0000_0003, 32'd2);
    tick();
    in_valid = 1'b0;
    tick();
    check("srl2_mid_out_valid", 32'(out_valid), 32'd0);
    tick();
    check("srl2_out_valid", 32'(out_valid), 32'd1);
    check("srl2_result", result, 32'h0);
    check("srl2_zero", 32'(zero), 32'd1);
`endif
    tick();
    check("drain_out_valid", 32'(out_valid), 32'd0);

    // Backpressure: result held while out_ready low, later input ignored.
    out_ready = 1'b0;
    issue(4'b0010, 32'd3, 32'd4);
    tick();
    issue(4'b0001, 32'd10, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall_result_%0d", i), result, 32'd7);
      check($sformatf("stall_out_valid_%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("stall_in_ready_%0d", i), 32'(in_ready), 32'd0);
      tick();
    end
    check("stall_hold_result", result, 32'd7);
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_out_valid", 32'(out_valid), 32'd1);
    check("b2b_result", result, 32'd9);
    tick();
    check("b2b_drain", 32'(out_valid), 32'd0);

`ifndef ALU_EXEC_BARREL_SHIFT_EN
    // Reset mid-SRL by 20: no result ever appears.
    issue(4'b0100, 32'hF000_0000, 32'd20);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_result", result, 32'h0);
    check("abort_zero", 32'(zero), 32'd0);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("abort_out_valid_%0d", i), 32'(out_valid), 32'd0);
      tick();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
